// File: rtl/reram_xbar_pkg.sv
// Shared types and sizing helpers for the ReRAM crossbar sequencer.
package reram_xbar_pkg;

    typedef enum logic [1:0] {
        OP_FORM  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MAC   = 2'b10,
        OP_ILL   = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_FORM,
        S_SET,
        S_RST,
        S_READ,
        S_SAMPLE,
        S_CAPTURE,
        S_GUARD,
        S_RESP
    } state_e;

    function automatic int max_cyc(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Index width that stays legal for a single-line array.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reram_xbar_ctrl_if.sv
// Command/response channel between host glue and the crossbar sequencer.
// Both directions use valid/ready; the sequencer side is the slave modport.
interface reram_xbar_ctrl_if
    import reram_xbar_pkg::*;
#(
    parameter int N_ROWS = 8,
    parameter int N_COLS = 8,
    parameter int ADC_W  = 4
);
    localparam int RW  = idx_w(N_ROWS);
    localparam int CLW = idx_w(N_COLS);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [RW-1:0]           cmd_row;
    logic [CLW-1:0]          cmd_col;
    logic [N_COLS-1:0]       cmd_data;
    logic [N_ROWS-1:0]       cmd_x;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [N_COLS*ADC_W-1:0] rsp_data;
    logic                    rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, cmd_x, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, cmd_x, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/reram_xbar_ctrl_timer.sv
// Phase down-counter: loads the phase length on entry, saturates at zero.
// o_done flags the last cycle of the loaded phase.
module xbar_phase_timer #(
    parameter int TW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_done
);
    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt <= TW'(1));

endmodule

// File: rtl/reram_xbar_ctrl.sv
// Sequencer for an N_ROWS x N_COLS 1T1R ReRAM crossbar: FORM / WRITE / MAC pulses and ADC capture.
// Latency FORM_CYC+3, 2*WRITE_CYC+3, READ_CYC+5 or 1 (illegal); one command in flight, response held until rsp_ready.
module reram_xbar_ctrl
    import reram_xbar_pkg::*;
#(
    parameter int N_ROWS    = 8,
    parameter int N_COLS    = 8,
    parameter int ADC_W     = 4,
    parameter int FORM_CYC  = 16,
    parameter int WRITE_CYC = 4,
    parameter int READ_CYC  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    reram_xbar_ctrl_if.slave        bus,
    output logic [N_ROWS-1:0]       o_wordline,
    output logic [N_COLS-1:0]       o_bitline,
    output logic [N_COLS-1:0]       o_selectline,
    output logic                    o_form,
    output logic                    o_wenable,
    output logic                    o_mac,
    output logic                    o_adc_sample,
    input  logic [N_COLS*ADC_W-1:0] i_adc_data,
    output logic                    o_busy
);
    localparam int RW  = idx_w(N_ROWS);
    localparam int CLW = idx_w(N_COLS);
    localparam int TW  = $clog2(max_cyc(FORM_CYC, 2 * WRITE_CYC, READ_CYC) + 1);
    localparam logic [N_ROWS-1:0] ROW_LSB = N_ROWS'(1);
    localparam logic [N_COLS-1:0] COL_LSB = N_COLS'(1);

    state_e                  r_state, w_state_nxt;
    op_e                     r_op, w_op;
    logic [RW-1:0]           r_row, w_row;
    logic [CLW-1:0]          r_col, w_col;
    logic [N_COLS-1:0]       r_data, w_data;
    logic [N_ROWS-1:0]       r_x, w_x;
    logic                    w_accept, w_ill;
    logic                    w_tmr_load, w_tmr_done;
    logic [TW-1:0]           w_tmr_val;
    logic [N_ROWS-1:0]       r_wl, w_wl;
    logic [N_COLS-1:0]       r_bl, w_bl, r_sl, w_sl;
    logic                    r_form, w_form, r_wen, w_wen, r_mac, w_mac, r_smp, w_smp;
    logic [N_COLS*ADC_W-1:0] r_rsp_data;
    logic                    r_rsp_err;

    assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

    // Line decode looks at the command as it will be latched, so registered drives line up with the state.
    assign w_op   = w_accept ? op_e'(bus.cmd_op) : r_op;
    assign w_row  = w_accept ? bus.cmd_row       : r_row;
    assign w_col  = w_accept ? bus.cmd_col       : r_col;
    assign w_data = w_accept ? bus.cmd_data      : r_data;
    assign w_x    = w_accept ? bus.cmd_x         : r_x;

    always_comb begin
        w_ill = 1'b0;
        case (op_e'(bus.cmd_op))
            OP_FORM:  w_ill = (int'(bus.cmd_row) >= N_ROWS) || (int'(bus.cmd_col) >= N_COLS);
            OP_WRITE: w_ill = (int'(bus.cmd_row) >= N_ROWS);
            OP_MAC:   w_ill = 1'b0;
            default:  w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.cmd_valid) w_state_nxt = w_ill ? S_RESP : S_SETUP;
            S_SETUP: begin
                case (r_op)
                    OP_FORM:  w_state_nxt = S_FORM;
                    OP_WRITE: w_state_nxt = S_SET;
                    default:  w_state_nxt = S_READ;
                endcase
            end
            S_FORM:    if (w_tmr_done) w_state_nxt = S_GUARD;
            S_SET:     if (w_tmr_done) w_state_nxt = S_RST;
            S_RST:     if (w_tmr_done) w_state_nxt = S_GUARD;
            S_READ:    if (w_tmr_done) w_state_nxt = S_SAMPLE;
            S_SAMPLE:  w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_GUARD;
            S_GUARD:   w_state_nxt = S_RESP;
            S_RESP:    if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tmr_val = '0;
        case (w_state_nxt)
            S_FORM:       w_tmr_val = TW'(FORM_CYC);
            S_SET, S_RST: w_tmr_val = TW'(WRITE_CYC);
            S_READ:       w_tmr_val = TW'(READ_CYC);
            default:      w_tmr_val = '0;
        endcase
        // SET -> RST is a state change too, so the second write phase reloads.
        w_tmr_load = (w_state_nxt != r_state) && (w_tmr_val != '0);
    end

    xbar_phase_timer #(.TW(TW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_wl   = '0;
        w_bl   = '0;
        w_sl   = '0;
        w_form = 1'b0;
        w_wen  = 1'b0;
        w_mac  = 1'b0;
        w_smp  = 1'b0;
        case (w_state_nxt)
            S_SETUP: begin
                case (w_op)
                    OP_FORM:  begin w_wl = ROW_LSB << w_row; w_bl = COL_LSB << w_col; end
                    OP_WRITE: begin w_wl = ROW_LSB << w_row; w_bl = w_data;           end
                    OP_MAC:   begin w_wl = w_x;              w_bl = '1;               end
                    default:  ;
                endcase
            end
            S_FORM: begin
                w_wl   = ROW_LSB << w_row;
                w_bl   = COL_LSB << w_col;
                w_form = 1'b1;
            end
            S_SET: begin
                w_wl  = ROW_LSB << w_row;
                w_bl  = w_data;
                w_wen = 1'b1;
            end
            S_RST: begin
                w_wl  = ROW_LSB << w_row;
                w_sl  = ~w_data;
                w_wen = 1'b1;
            end
            S_READ, S_SAMPLE: begin
                w_wl  = w_x;
                w_bl  = '1;
                w_mac = 1'b1;
                w_smp = (w_state_nxt == S_SAMPLE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_FORM;
            r_row      <= '0;
            r_col      <= '0;
            r_data     <= '0;
            r_x        <= '0;
            r_wl       <= '0;
            r_bl       <= '0;
            r_sl       <= '0;
            r_form     <= 1'b0;
            r_wen      <= 1'b0;
            r_mac      <= 1'b0;
            r_smp      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op;
            r_row   <= w_row;
            r_col   <= w_col;
            r_data  <= w_data;
            r_x     <= w_x;
            r_wl    <= w_wl;
            r_bl    <= w_bl;
            r_sl    <= w_sl;
            r_form  <= w_form;
            r_wen   <= w_wen;
            r_mac   <= w_mac;
            r_smp   <= w_smp;
            if (w_accept) begin
                r_rsp_data <= '0;
                r_rsp_err  <= w_ill;
            end else if (r_state == S_CAPTURE) begin
                r_rsp_data <= i_adc_data;
            end
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign o_busy        = (r_state != S_IDLE);
    assign o_wordline    = r_wl;
    assign o_bitline     = r_bl;
    assign o_selectline  = r_sl;
    assign o_form        = r_form;
    assign o_wenable     = r_wen;
    assign o_mac         = r_mac;
    assign o_adc_sample  = r_smp;

endmodule
